// File: rtl/uart_rx_word.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_word
// Purpose  : Single-clock 16x-oversampling UART receiver that collects NBYTES
//            consecutive bytes into one word, first byte in the top byte.
//            Optional even parity (8E1) when UART_RX_PARITY_EN is defined;
//            otherwise 8N1 and parity_err_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_word #(
    parameter int CLK_DIV      = 81,
    parameter int NBYTES       = 2,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  rx,
    output logic [8*NBYTES-1:0]   data_o,
    output logic                  valid_o,
    output logic                  frame_err_o,
    output logic                  parity_err_o,
    output logic                  timeout_o
);

    localparam int c_DIV_W    = $clog2(CLK_DIV);
    localparam int c_IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int c_TO_LIMIT = TIMEOUT_BITS * 16;
    localparam int c_TO_W     = $clog2(c_TO_LIMIT + 1);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NBYTES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(c_TO_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
        ,S_PARITY = 3'd4
`endif
    } state_t;

    state_t               r_state;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [c_DIV_W-1:0]   r_div;
    logic [3:0]           r_smp;
    logic [2:0]           r_bit;
    logic [7:0]           r_shift;
    logic [8*NBYTES-1:0]  r_buf;
    logic [c_IDX_W-1:0]   r_byte_idx;
    logic [c_TO_W-1:0]    r_idle_cnt;
    logic                 w_tick;
    logic [8*NBYTES-1:0]  w_word_next;

    // Two-flop synchronizer for the asynchronous serial pin (idles high)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Oversample tick divider, held at zero while disabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (!enable || (r_div == c_DIV_LAST)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_tick = enable && (r_div == c_DIV_LAST);

    // Word with the freshly received byte appended as the least significant byte
    generate
        if (NBYTES == 1) begin : g_word_single
            assign w_word_next = r_shift;
        end else begin : g_word_multi
            assign w_word_next = {r_buf[8*NBYTES-9:0], r_shift};
        end
    endgenerate

`ifdef UART_RX_PARITY_EN
    logic r_par;
    logic w_par_ok;
    assign w_par_ok = ~(^{r_shift, r_par});
`else
    assign parity_err_o = 1'b0;
`endif

    // Receive FSM: frame sampling, byte assembly, inter-byte timeout, pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_smp       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_buf       <= '0;
            r_byte_idx  <= '0;
            r_idle_cnt  <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            timeout_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par        <= 1'b0;
            parity_err_o <= 1'b0;
`endif
        end else begin
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            timeout_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif
            if (!enable) begin
                r_state    <= S_IDLE;
                r_smp      <= '0;
                r_byte_idx <= '0;
                r_idle_cnt <= '0;
            end else if (w_tick) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_rx_s) begin
                            r_state    <= S_START;
                            r_smp      <= '0;
                            r_idle_cnt <= '0;
                        end else if (r_byte_idx != '0) begin
                            if (r_idle_cnt == c_TO_LAST) begin
                                timeout_o  <= 1'b1;
                                r_byte_idx <= '0;
                                r_idle_cnt <= '0;
                            end else begin
                                r_idle_cnt <= r_idle_cnt + 1'b1;
                            end
                        end
                    end
                    S_START: begin
                        if (r_smp == 4'd7) begin
                            r_smp <= '0;
                            r_bit <= '0;
                            // A start bit that has gone high by mid-bit is a glitch
                            r_state <= r_rx_s ? S_IDLE : S_DATA;
                        end else begin
                            r_smp <= r_smp + 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_smp <= r_smp + 1'b1;
                        if (r_smp == 4'd15) begin
                            r_shift <= {r_rx_s, r_shift[7:1]};
                            r_bit   <= r_bit + 1'b1;
                            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_STOP;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        r_smp <= r_smp + 1'b1;
                        if (r_smp == 4'd15) begin
                            r_par   <= r_rx_s;
                            r_state <= S_STOP;
                        end
                    end
`endif
                    S_STOP: begin
                        r_smp <= r_smp + 1'b1;
                        // Decide at mid-stop so back-to-back frames are caught
                        if (r_smp == 4'd15) begin
                            r_state <= S_IDLE;
                            if (!r_rx_s) begin
                                frame_err_o <= 1'b1;
                                r_byte_idx  <= '0;
`ifdef UART_RX_PARITY_EN
                            end else if (!w_par_ok) begin
                                parity_err_o <= 1'b1;
                                r_byte_idx   <= '0;
`endif
                            end else begin
                                r_buf <= w_word_next;
                                if (r_byte_idx == c_IDX_LAST) begin
                                    data_o     <= w_word_next;
                                    valid_o    <= 1'b1;
                                    r_byte_idx <= '0;
                                end else begin
                                    r_byte_idx <= r_byte_idx + c_IDX_W'(1);
                                end
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_word
// Purpose  : Directed self-checking bench for uart_rx_word (CLK_DIV=4,
//            NBYTES=2, TIMEOUT_BITS=4, one bit = 64 clk).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_word;

    localparam int BIT_CLK = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        rx;
    logic [15:0] data_o;
    logic        valid_o;
    logic        frame_err_o;
    logic        parity_err_o;
    logic        timeout_o;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;
    int n_frame = 0;
    int n_par = 0;
    int n_to = 0;
    int n_multi = 0;
    logic [15:0] last_data = '0;

    uart_rx_word #(
        .CLK_DIV      (4),
        .NBYTES       (2),
        .TIMEOUT_BITS (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .rx           (rx),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts every high cycle, so a stretched pulse is visible
    always @(negedge clk) begin
        if (valid_o) begin
            n_valid   <= n_valid + 1;
            last_data <= data_o;
        end
        if (frame_err_o)  n_frame <= n_frame + 1;
        if (parity_err_o) n_par   <= n_par + 1;
        if (timeout_o)    n_to    <= n_to + 1;
        if ((int'(valid_o) + int'(frame_err_o) + int'(parity_err_o) + int'(timeout_o)) > 1)
            n_multi <= n_multi + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One frame; stop_ok=0 holds the stop bit low only past its sample point
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic par_bad);
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clk(BIT_CLK);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_bad;
        wait_clk(BIT_CLK);
`else
        if (par_bad) rx = 1'b1;
`endif
        if (stop_ok) begin
            rx = 1'b1;
            wait_clk(BIT_CLK);
        end else begin
            rx = 1'b0;
            wait_clk(40);
            rx = 1'b1;
            wait_clk(24);
        end
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b1, 1'b0);
    endtask

    initial begin
        rx      = 1'b1;
        enable  = 1'b1;
        reset_n = 1'b0;
        wait_clk(3);
        check("rst_data",   32'(data_o), 32'h0);
        check("rst_valid",  32'(valid_o), 32'h0);
        check("rst_frame",  32'(frame_err_o), 32'h0);
        check("rst_parity", 32'(parity_err_o), 32'h0);
        check("rst_timeout", 32'(timeout_o), 32'h0);
        reset_n = 1'b1;
        wait_clk(8);
        check("idle_data", 32'(data_o), 32'h0);

        // Back-to-back word
        send(8'hA5);
        send(8'h3C);
        wait_clk(2*BIT_CLK);
        check("w1_count", 32'(n_valid), 32'd1);
        check("w1_last",  32'(last_data), 32'hA53C);
        check("w1_hold",  32'(data_o), 32'hA53C);
        check("w1_frame", 32'(n_frame), 32'd0);

        // Bad stop bit drops the byte and restarts the word
        send_frame(8'h11, 1'b0, 1'b0);
        wait_clk(2*BIT_CLK);
        check("fe_count", 32'(n_frame), 32'd1);
        check("fe_novalid", 32'(n_valid), 32'd1);
        send(8'h22);
        send(8'h33);
        wait_clk(2*BIT_CLK);
        check("fe_word",  32'(last_data), 32'h2233);
        check("fe_valid", 32'(n_valid), 32'd2);

        // Start glitch of 4 ticks is rejected silently
        rx = 1'b0;
        wait_clk(16);
        rx = 1'b1;
        wait_clk(2*BIT_CLK);
        check("gl_quiet", 32'(n_valid + n_frame + n_to), 32'd3);
        send(8'h01);
        send(8'h02);
        wait_clk(2*BIT_CLK);
        check("gl_word", 32'(last_data), 32'h0102);
        check("gl_valid", 32'(n_valid), 32'd3);

        // 3 idle bit-times between bytes stays under the 4-bit timeout
        send(8'h12);
        wait_clk(3*BIT_CLK);
        send(8'h34);
        wait_clk(2*BIT_CLK);
        check("gap_word", 32'(last_data), 32'h1234);
        check("gap_noto", 32'(n_to), 32'd0);

        // 5 idle bit-times discards the partial word
        send(8'h55);
        wait_clk(5*BIT_CLK);
        check("to_count", 32'(n_to), 32'd1);
        send(8'h66);
        send(8'h77);
        wait_clk(2*BIT_CLK);
        check("to_word",  32'(last_data), 32'h6677);
        check("to_valid", 32'(n_valid), 32'd5);
        check("to_once",  32'(n_to), 32'd1);

        // Disabling mid-frame aborts silently and clears the byte index
        send(8'h13);
        rx = 1'b0;
        wait_clk(200);
        enable = 1'b0;
        rx = 1'b1;
        wait_clk(100);
        check("en_hold", 32'(data_o), 32'h6677);
        enable = 1'b1;
        wait_clk(2*BIT_CLK);
        send(8'h24);
        send(8'h68);
        wait_clk(2*BIT_CLK);
        check("en_word",  32'(last_data), 32'h2468);
        check("en_valid", 32'(n_valid), 32'd6);
        check("en_quiet", 32'(n_frame + n_to), 32'd2);

        // Asynchronous reset in the middle of the second byte
        send(8'h9A);
        rx = 1'b0;
        wait_clk(300);
        reset_n = 1'b0;
        rx = 1'b1;
        #1;
        check("ar_data",  32'(data_o), 32'h0);
        check("ar_valid", 32'(valid_o), 32'h0);
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(2*BIT_CLK);
        send(8'hDE);
        send(8'hAD);
        wait_clk(2*BIT_CLK);
        check("ar_word",  32'(last_data), 32'hDEAD);
        check("ar_valid2", 32'(n_valid), 32'd7);

`ifdef UART_RX_PARITY_EN
        // Wrong parity on 0x07 drops it; the next pair assembles normally
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        check("pe_count", 32'(n_par), 32'd1);
        send(8'h07);
        send(8'h08);
        wait_clk(2*BIT_CLK);
        check("pe_word",  32'(last_data), 32'h0708);
        check("pe_valid", 32'(n_valid), 32'd8);
`else
        check("pe_none", 32'(n_par), 32'd0);
`endif

        check("final_frame", 32'(n_frame), 32'd1);
        check("final_to",    32'(n_to), 32'd1);
        check("onehot",      32'(n_multi), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_word.md
# uart_rx_word

Parametrised single-clock UART receiver that assembles NBYTES consecutive 8N1 (or 8E1) bytes into one word. First byte lands in the most significant byte. Runs entirely on the system clock, with a clock-enable oversample tick instead of a derived clock. Sits between the board RX pin and the PUF challenge/command logic, and replaces the fixed 2-byte and 1-byte receivers.

## Interface
Parameters:
- CLK_DIV, 81 — system clocks per 1/16-bit oversample tick; 81 gives 115200 baud at 150 MHz. Must be ≥ 2.
- NBYTES, 2 — bytes per assembled word; legal range 1–16.
- TIMEOUT_BITS, 32 — idle bit-times allowed between bytes of one word before the partial word is discarded.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  when low: FSM held in IDLE, byte index cleared, tick counter cleared; outputs keep their last values.
- rx  in  1  serial input; idle high; asynchronous to clk.
- data_o  out  8*NBYTES  assembled word; byte 0 received is data_o[8*NBYTES-1 -: 8].
- valid_o  out  1  one-clk pulse when data_o has been updated.
- frame_err_o  out  1  one-clk pulse when a stop bit is sampled low.
- parity_err_o  out  1  one-clk pulse when parity fails; tied 0 without the macro.
- timeout_o  out  1  one-clk pulse when a partial word is discarded for inactivity.

## Operation
- rx passes through a 2-flop synchronizer (rx_s) before any use.
- Tick generator: counter 0..CLK_DIV-1, free-running while enable=1; tick=1 for the one clk where count==CLK_DIV-1.
- All FSM activity below happens only on tick cycles. Sample counter `smp` is 4 bits and wraps 15→0.
- FSM states:
  - IDLE: on rx_s==0 → START, smp=0.
  - START: at smp==7, rx_s==0 → DATA, smp=0, bit=0. rx_s==1 at smp==7 → IDLE (glitch rejected, no error).
  - DATA: at smp==15, shift in rx_s, LSB first, and increment bit. Since smp counts from mid-start, smp==15 is mid-bit. After bit 7 → PARITY if the macro is on, else STOP.
  - PARITY: at smp==15, latch rx_s → STOP.
  - STOP: at smp==15, evaluate the stop bit (see below), then → IDLE. The remaining half stop bit is not waited for, so back-to-back frames are accepted.
- Stop-bit evaluation:
  - Good: stop==1 and parity ok. The byte is written into slot byte_idx and byte_idx increments.
  - byte_idx==NBYTES-1 on a good byte: the full word is copied to data_o, valid_o pulses, byte_idx=0.
  - stop==0: frame_err_o pulses, byte dropped, byte_idx=0.
  - Parity bad with stop==1: parity_err_o pulses, byte dropped, byte_idx=0.
  - stop==0 and parity bad together: only frame_err_o pulses.
- Timeout: while in IDLE with byte_idx≠0, an idle-tick counter increments. It reaches TIMEOUT_BITS*16 → timeout_o pulses, byte_idx=0, counter cleared. Any entry to START clears the counter.
- NBYTES=1: every good byte produces valid_o, and timeout never fires.
- enable falling mid-frame aborts the frame silently, with no error pulse.

## Timing
- Reset values: data_o=0, valid_o=0, frame_err_o=0, parity_err_o=0, timeout_o=0. Internally: FSM=IDLE, byte_idx=0, all counters 0.
- Synchronizer adds 2 clk from pin to rx_s.
- valid_o, frame_err_o, parity_err_o and timeout_o are registered. They are high for exactly the one clk after the tick on which the condition is decided.
- data_o changes in the same clk that valid_o rises, and holds until the next valid_o.
- Word latency: valid_o rises 1 clk after the mid-stop-bit tick of the last byte.
- At most one of the four pulses is high in any clk.
- reset_n assertion takes effect immediately, mid-frame included. Deassertion is used as-is; the integrator synchronizes it.

## Configuration
- UART_RX_PARITY_EN defined: frame is 8E1, with a PARITY state. Parity is checked as XOR(data, parity bit)==0 and parity_err_o is live.
- Undefined: frame is 8N1, the PARITY state is not compiled, and parity_err_o is constant 0.

## Test plan
- CLK_DIV=4, NBYTES=2: send 0xA5 then 0x3C back-to-back at 1/(64 clk) bit rate → data_o=16'hA53C, valid_o high for 1 clk, no error pulses.
- Stop bit forced 0 on byte 0x11, then send 0x22, 0x33 → frame_err_o pulses once, then data_o=16'h2233 with valid_o.
- rx low for 4 ticks only, then high → FSM returns to IDLE, no pulses, and a following 0x01, 0x02 gives 16'h0102.
- TIMEOUT_BITS=4: send 0x55, idle 5 bit-times, send 0x66, 0x77 → timeout_o pulses once, then data_o=16'h6677.
- UART_RX_PARITY_EN: send 0x07 with parity bit 0, then 0x07/1 and 0x08/1 → parity_err_o pulses on the first byte, then data_o=16'h0708.
- reset_n low for 3 clk in the middle of byte 2 of a word → all outputs 0 immediately; the next full word is received correctly.
